histeq_sequencer: RTL and testbench

//  Frame-level controller for the histogram equalizer. Sequences the stages CLEAR -> INPUT -> CDF -> OUTPUT
//  for each frame and owns the ping-pong scratchpad bank bit (drives inputBaseOffset).

---
 rtl/histeq_pkg.sv | 24 ++
 rtl/histeq_m2_arbiter.sv | 52 +++++
 rtl/histeq_sequencer.sv | 138 +++++++++++++
 tb/tb_histeq_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histeq_pkg.sv
// Shared sizes, encodings and scratchpad constants for the histogram-equalizer frame sequencer.
package histeq_pkg;

    localparam int BINS    = 256;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 36;
    localparam int TIMEOUT = 2**20 - 1;
    localparam int WD_W    = 20;

    // A cleared bin carries no valid tag, so the histogram stage treats it as empty.
    localparam logic [35:0] CLEAR_WORD = 36'h0;
    localparam logic [15:0] VALID_TAG  = 16'hAAAA;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_INPUT  = 3'd2,
        ST_CDF    = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/histeq_m2_arbiter.sv
// State-selected mux of the three m2 scratchpad requesters; ungranted requests are simply dropped.
module histeq_m2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 36
) (
    input  histeq_pkg::state_t  state,
    input  logic                clr_we,
    input  logic [ADDR_W-1:0]   clr_waddr,
    input  logic [DATA_W-1:0]   clr_wbus,
    input  logic                in_we,
    input  logic [ADDR_W-1:0]   in_waddr,
    input  logic [DATA_W-1:0]   in_wbus,
    input  logic [ADDR_W-1:0]   in_raddr,
    input  logic                cdf_we,
    input  logic [ADDR_W-1:0]   cdf_waddr,
    input  logic [DATA_W-1:0]   cdf_wbus,
    input  logic [ADDR_W-1:0]   cdf_raddr,
    output logic                m2_we,
    output logic [ADDR_W-1:0]   m2_waddr,
    output logic [DATA_W-1:0]   m2_wbus,
    output logic [ADDR_W-1:0]   m2_raddr
);
    import histeq_pkg::*;

    always_comb begin
        m2_we    = 1'b0;
        m2_waddr = '0;
        m2_wbus  = '0;
        m2_raddr = '0;
        case (state)
            ST_CLEAR: begin
                m2_we    = clr_we;
                m2_waddr = clr_waddr;
                m2_wbus  = clr_wbus;
            end
            ST_INPUT: begin
                m2_we    = in_we;
                m2_waddr = in_waddr;
                m2_wbus  = in_wbus;
                m2_raddr = in_raddr;
            end
            ST_CDF: begin
                m2_we    = cdf_we;
                m2_waddr = cdf_waddr;
                m2_wbus  = cdf_wbus;
                m2_raddr = cdf_raddr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/histeq_sequencer.sv
// Frame sequencer for the histogram equalizer: CLEAR -> INPUT -> CDF -> OUTPUT per frame,
// ping-pong bank ownership, m2 port arbitration and a per-stage watchdog.
module histeq_sequencer #(
    parameter int BINS    = histeq_pkg::BINS,
    parameter int ADDR_W  = histeq_pkg::ADDR_W,
    parameter int DATA_W  = histeq_pkg::DATA_W,
    parameter int TIMEOUT = histeq_pkg::TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    input  logic              clear_err,
    output logic              busy,
    output logic              frame_done,
    output logic              error,
    output logic              bank,
    output logic              in_start,
    input  logic              in_done,
    output logic              cdf_start,
    input  logic              cdf_done,
    output logic              out_start,
    input  logic              out_done,
    input  logic              in_m2WE,
    input  logic [ADDR_W-1:0] in_m2WriteAddr,
    input  logic [DATA_W-1:0] in_m2WriteBus,
    input  logic [ADDR_W-1:0] in_m2ReadAddr,
    input  logic              cdf_m2WE,
    input  logic [ADDR_W-1:0] cdf_m2WriteAddr,
    input  logic [DATA_W-1:0] cdf_m2WriteBus,
    input  logic [ADDR_W-1:0] cdf_m2ReadAddr,
    output logic              m2WE,
    output logic [ADDR_W-1:0] m2WriteAddr,
    output logic [DATA_W-1:0] m2WriteBus,
    output logic [ADDR_W-1:0] m2ReadAddr,
    output logic [2:0]        dbg_state
);
    import histeq_pkg::*;

    localparam int CNT_W = $clog2(BINS) + 1;

    state_t            state_q;
    state_t            state_n;
    logic [CNT_W-1:0]  clr_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_expired;
    logic              last_bin;
    logic [ADDR_W-1:0] clr_waddr;
    logic [DATA_W-1:0] clr_wbus;

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign last_bin   = (clr_cnt == CNT_W'(BINS - 1));
    assign clr_waddr  = {bank, (ADDR_W-1)'(clr_cnt)};
    assign clr_wbus   = DATA_W'(CLEAR_WORD);
    assign dbg_state  = state_q;

    // A stage's own done beats its watchdog; abort beats everything but reset.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:   if (go) state_n = ST_CLEAR;
            ST_CLEAR:  if (last_bin) state_n = ST_INPUT;
            ST_INPUT:  if (in_done) state_n = ST_CDF;
                       else if (wd_expired) state_n = ST_ERROR;
            ST_CDF:    if (cdf_done) state_n = ST_OUTPUT;
                       else if (wd_expired) state_n = ST_ERROR;
            ST_OUTPUT: if (out_done) state_n = ST_DONE;
                       else if (wd_expired) state_n = ST_ERROR;
            ST_DONE:   state_n = ST_IDLE;
            ST_ERROR:  if (clear_err) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
        if (abort) state_n = ST_IDLE;
    end

    // Control outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_cnt    <= '0;
            wd_cnt     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
            bank       <= 1'b0;
            in_start   <= 1'b0;
            cdf_start  <= 1'b0;
            out_start  <= 1'b0;
        end else begin
            state_q    <= state_n;
            busy       <= (state_n != ST_IDLE);
            frame_done <= (state_n == ST_DONE);
            in_start   <= (state_n == ST_INPUT);
            cdf_start  <= (state_n == ST_CDF) && (state_q != ST_CDF);
            out_start  <= (state_n == ST_OUTPUT) && (state_q != ST_OUTPUT);
            clr_cnt    <= (state_q == ST_CLEAR && state_n == ST_CLEAR) ? clr_cnt + 1'b1 : '0;

            if (state_n != state_q)
                wd_cnt <= '0;
            else if (wd_cnt != '1)
                wd_cnt <= wd_cnt + 1'b1;

            if (state_q == ST_DONE && !abort)
                bank <= ~bank;

            if (state_n == ST_ERROR)
                error <= 1'b1;
            else if (state_q == ST_ERROR && clear_err && !abort)
                error <= 1'b0;
        end
    end

    histeq_m2_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_arb (
        .state     (state_q),
        .clr_we    (1'b1),
        .clr_waddr (clr_waddr),
        .clr_wbus  (clr_wbus),
        .in_we     (in_m2WE),
        .in_waddr  (in_m2WriteAddr),
        .in_wbus   (in_m2WriteBus),
        .in_raddr  (in_m2ReadAddr),
        .cdf_we    (cdf_m2WE),
        .cdf_waddr (cdf_m2WriteAddr),
        .cdf_wbus  (cdf_m2WriteBus),
        .cdf_raddr (cdf_m2ReadAddr),
        .m2_we     (m2WE),
        .m2_waddr  (m2WriteAddr),
        .m2_wbus   (m2WriteBus),
        .m2_raddr  (m2ReadAddr)
    );

    a_clear_untagged: assert property (@(posedge clock) disable iff (reset)
        (m2WE && state_q == ST_CLEAR) |-> (m2WriteBus[DATA_W-1 -: 16] != VALID_TAG));

endmodule

// File: tb/tb_histeq_sequencer.sv
// Randomized bench for histeq_sequencer against a phase-level frame model with a clear-write scoreboard.
module tb_histeq_sequencer;

    localparam int TO   = 100;
    localparam int BINS = 256;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_INPUT = 2, P_CDF = 3, P_OUTPUT = 4, P_DONE = 5, P_ERROR = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0, abort = 1'b0, clear_err = 1'b0;
    logic        busy, frame_done, error, bank, in_start, cdf_start, out_start;
    logic        in_done = 1'b0, cdf_done = 1'b0, out_done = 1'b0;
    logic        in_m2WE = 1'b0, cdf_m2WE = 1'b0;
    logic [15:0] in_m2WriteAddr = '0, in_m2ReadAddr = '0, cdf_m2WriteAddr = '0, cdf_m2ReadAddr = '0;
    logic [35:0] in_m2WriteBus = '0, cdf_m2WriteBus = '0;
    logic        m2WE;
    logic [15:0] m2WriteAddr, m2ReadAddr;
    logic [35:0] m2WriteBus;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    histeq_sequencer #(.BINS(BINS), .ADDR_W(16), .DATA_W(36), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .go(go), .abort(abort), .clear_err(clear_err),
        .busy(busy), .frame_done(frame_done), .error(error), .bank(bank),
        .in_start(in_start), .in_done(in_done), .cdf_start(cdf_start), .cdf_done(cdf_done),
        .out_start(out_start), .out_done(out_done),
        .in_m2WE(in_m2WE), .in_m2WriteAddr(in_m2WriteAddr), .in_m2WriteBus(in_m2WriteBus),
        .in_m2ReadAddr(in_m2ReadAddr),
        .cdf_m2WE(cdf_m2WE), .cdf_m2WriteAddr(cdf_m2WriteAddr), .cdf_m2WriteBus(cdf_m2WriteBus),
        .cdf_m2ReadAddr(cdf_m2ReadAddr),
        .m2WE(m2WE), .m2WriteAddr(m2WriteAddr), .m2WriteBus(m2WriteBus), .m2ReadAddr(m2ReadAddr),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stage stubs and random m2 requesters ----------------
    int in_lat = 50, cdf_lat = 20, out_lat = 10;
    bit in_en = 1'b1;
    bit fixed_req = 1'b0;
    int in_cnt = 0, cdf_pend = 0, out_pend = 0;

    always @(posedge clock) begin
        #1;
        in_done  = 1'b0;
        cdf_done = 1'b0;
        out_done = 1'b0;
        if (reset || !busy) begin
            in_cnt = 0; cdf_pend = 0; out_pend = 0;
        end else begin
            if (in_start && in_en) begin
                in_cnt++;
                if (in_cnt == in_lat) in_done = 1'b1;
            end else begin
                in_cnt = 0;
            end
            if (cdf_start) cdf_pend = cdf_lat;
            else if (cdf_pend > 0) begin
                cdf_pend--;
                if (cdf_pend == 0) cdf_done = 1'b1;
            end
            if (out_start) out_pend = out_lat;
            else if (out_pend > 0) begin
                out_pend--;
                if (out_pend == 0) out_done = 1'b1;
            end
        end
        if (fixed_req) begin
            in_m2WE = 1'b1;  in_m2WriteAddr = 16'h1234;  in_m2WriteBus = 36'h5;  in_m2ReadAddr = 16'h1111;
            cdf_m2WE = 1'b1; cdf_m2WriteAddr = 16'h4321; cdf_m2WriteBus = 36'h7; cdf_m2ReadAddr = 16'h2222;
        end else begin
            in_m2WE         = 1'($urandom);
            in_m2WriteAddr  = 16'($urandom);
            in_m2WriteBus   = {4'($urandom), 32'($urandom)};
            in_m2ReadAddr   = 16'($urandom);
            cdf_m2WE        = 1'($urandom);
            cdf_m2WriteAddr = 16'($urandom);
            cdf_m2WriteBus  = {4'($urandom), 32'($urandom)};
            cdf_m2ReadAddr  = 16'($urandom);
        end
    end

    // ---------------- behavioural model ----------------
    int          m_phase = P_IDLE;
    int          m_age   = 0;
    logic        m_bank  = 1'b0;
    logic        m_err   = 1'b0;
    bit          m_valid = 1'b0;
    logic [15:0] exp_q[$];

    always @(posedge clock) begin
        int nxt;
        m_valid = 1'b1;
        if (reset) begin
            m_phase = P_IDLE; m_age = 0; m_bank = 1'b0; m_err = 1'b0;
            exp_q.delete();
        end else begin
            nxt = m_phase;
            case (m_phase)
                P_IDLE:   if (go) nxt = P_CLEAR;
                P_CLEAR:  if (m_age == BINS - 1) nxt = P_INPUT;
                P_INPUT:  if (in_done) nxt = P_CDF;    else if (m_age == TO - 1) nxt = P_ERROR;
                P_CDF:    if (cdf_done) nxt = P_OUTPUT; else if (m_age == TO - 1) nxt = P_ERROR;
                P_OUTPUT: if (out_done) nxt = P_DONE;  else if (m_age == TO - 1) nxt = P_ERROR;
                P_DONE:   nxt = P_IDLE;
                P_ERROR:  if (clear_err) nxt = P_IDLE;
                default:  nxt = P_IDLE;
            endcase
            if (abort) nxt = P_IDLE;
            if (m_phase == P_DONE && !abort) m_bank = ~m_bank;
            if (nxt == P_ERROR) m_err = 1'b1;
            else if (m_phase == P_ERROR && clear_err && !abort) m_err = 1'b0;
            if (abort) exp_q.delete();
            if (m_phase == P_IDLE && nxt == P_CLEAR)
                for (int i = 0; i < BINS; i++) exp_q.push_back({m_bank, 15'(i)});
            m_age   = (nxt == m_phase) ? m_age + 1 : 0;
            m_phase = nxt;
        end
    end

    // ---------------- scoreboard / compare ----------------
    int          wr_count = 0, fd_count = 0, in_hi = 0;
    logic [15:0] burst_first = '0, last_addr = '0;
    bit          prev_clr = 1'b0;

    always @(negedge clock) begin
        logic [15:0] ea;
        if (m_valid) begin
            chk("busy",       busy,       m_phase != P_IDLE);
            chk("frame_done", frame_done, m_phase == P_DONE);
            chk("error",      error,      m_err);
            chk("bank",       bank,       m_bank);
            chk("in_start",   in_start,   m_phase == P_INPUT);
            chk("cdf_start",  cdf_start,  m_phase == P_CDF && m_age == 0);
            chk("out_start",  out_start,  m_phase == P_OUTPUT && m_age == 0);
            case (m_phase)
                P_CLEAR: begin
                    chk("clear_queue_nonempty", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        ea = exp_q.pop_front();
                        chk("clr_we",    m2WE,        1'b1);
                        chk("clr_addr",  m2WriteAddr, ea);
                        chk("clr_data",  m2WriteBus,  36'h0);
                        chk("clr_raddr", m2ReadAddr,  16'h0);
                    end
                end
                P_INPUT: begin
                    chk("in_we",    m2WE,        in_m2WE);
                    chk("in_waddr", m2WriteAddr, in_m2WriteAddr);
                    chk("in_wbus",  m2WriteBus,  in_m2WriteBus);
                    chk("in_raddr", m2ReadAddr,  in_m2ReadAddr);
                end
                P_CDF: begin
                    chk("cdf_we",    m2WE,        cdf_m2WE);
                    chk("cdf_waddr", m2WriteAddr, cdf_m2WriteAddr);
                    chk("cdf_wbus",  m2WriteBus,  cdf_m2WriteBus);
                    chk("cdf_raddr", m2ReadAddr,  cdf_m2ReadAddr);
                end
                default: begin
                    chk("idle_we",    m2WE,        1'b0);
                    chk("idle_waddr", m2WriteAddr, 16'h0);
                    chk("idle_wbus",  m2WriteBus,  36'h0);
                    chk("idle_raddr", m2ReadAddr,  16'h0);
                end
            endcase
            if (m_phase == P_CLEAR && m2WE) begin
                if (!prev_clr) burst_first = m2WriteAddr;
                last_addr = m2WriteAddr;
                wr_count++;
            end
            prev_clr = (m_phase == P_CLEAR && m2WE);
            if (frame_done) fd_count++;
            if (in_start) in_hi++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        cycle();
        go = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [15:0] base, input logic exp_bank);
        int w0, f0, n;
        w0 = wr_count;
        f0 = fd_count;
        pulse_go();
        n = 0;
        while (busy && n < 2000) begin cycle(); n++; end
        chk({name, "_in_time"}, n < 2000, 1'b1);
        chk({name, "_writes"},  wr_count - w0, 256);
        chk({name, "_first"},   burst_first, base);
        chk({name, "_last"},    last_addr, base + 16'h00FF);
        chk({name, "_fd"},      fd_count - f0, 1);
        chk({name, "_bank"},    bank, exp_bank);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, w0, f0, i0;

        repeat (3) cycle();
        reset = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_bank", bank, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_m2we", m2WE, 1'b0);

        run_frame("f1", 16'h0000, 1'b1);
        run_frame("f2", 16'h8000, 1'b0);

        // watchdog: input stage never answers
        in_en = 1'b0;
        i0 = in_hi;
        pulse_go();
        n = 0;
        while (!error && n < 2000) begin cycle(); n++; end
        chk("to_reached", n < 2000, 1'b1);
        chk("to_in_cycles", in_hi - i0, TO);
        chk("to_in_start", in_start, 1'b0);
        chk("to_m2we", m2WE, 1'b0);
        chk("to_busy", busy, 1'b1);
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        chk("clr_err_error", error, 1'b0);
        chk("clr_err_busy", busy, 1'b0);
        chk("clr_err_bank", bank, 1'b0);
        in_en = 1'b1;

        // abort in the middle of the clear sweep
        w0 = wr_count;
        f0 = fd_count;
        pulse_go();
        n = 0;
        while (!(m2WE && m2WriteAddr == 16'h0025) && n < 1000) begin @(negedge clock); n++; end
        chk("ab_found", n < 1000, 1'b1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("ab_busy", busy, 1'b0);
        chk("ab_m2we", m2WE, 1'b0);
        chk("ab_writes", wr_count - w0, 38);
        chk("ab_fd", fd_count - f0, 0);
        chk("ab_bank", bank, 1'b0);

        // go held through DONE, with fixed competing requests
        fixed_req = 1'b1;
        cycle();
        f0 = fd_count;
        go = 1'b1;
        n = 0;
        while (!in_start && n < 1000) begin cycle(); n++; end
        chk("arb_found", n < 1000, 1'b1);
        chk("arb_we", m2WE, 1'b1);
        chk("arb_waddr", m2WriteAddr, 16'h1234);
        chk("arb_raddr", m2ReadAddr, 16'h1111);
        n = 0;
        while (fd_count - f0 < 2 && n < 3000) begin @(negedge clock); n++; end
        chk("held_two_frames", n < 3000, 1'b1);
        go = 1'b0;
        cycle();
        n = 0;
        while (busy && n < 2000) begin cycle(); n++; end
        chk("held_idle", busy, 1'b0);
        chk("held_bank", bank, 1'b0);
        fixed_req = 1'b0;

        // reset in the middle of OUTPUT with bank = 1
        run_frame("f3", 16'h0000, 1'b1);
        pulse_go();
        n = 0;
        while (!out_start && n < 2000) begin cycle(); n++; end
        chk("rs_found", n < 2000, 1'b1);
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        chk("rs_busy", busy, 1'b0);
        chk("rs_bank", bank, 1'b0);
        chk("rs_error", error, 1'b0);
        chk("rs_out_start", out_start, 1'b0);
        chk("rs_frame_done", frame_done, 1'b0);
        chk("rs_m2we", m2WE, 1'b0);
        reset = 1'b0;

        // random soak
        for (int c = 0; c < 4000; c++) begin
            go        = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 399) == 0);
            clear_err = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) in_en = ~in_en;
            if (!busy) begin
                in_lat  = $urandom_range(1, 60);
                cdf_lat = $urandom_range(1, 30);
                out_lat = $urandom_range(1, 30);
            end
            cycle();
        end
        go = 1'b0;
        clear_err = 1'b0;
        in_en = 1'b1;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("soak_abort_idle", busy, 1'b0);
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
